// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (m0 wins).
module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        pick_m1;
  logic        in_access, in_resp;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // last_q = 1 means requester 1 was granted most recently
  logic last_q, last_d;
  assign pick_m1 = m1_valid && (!m0_valid || !last_q);
`else
  assign pick_m1 = m1_valid && !m0_valid;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = ACCESS;
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          addr_d  = pick_m1 ? m1_addr  : m0_addr;
          wdata_d = pick_m1 ? m1_wdata : m0_wdata;
          wstrb_d = pick_m1 ? m1_wstrb : m0_wstrb;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
          last_d  = pick_m1;
`endif
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q  <= last_d;
`endif
    end
  end

  // Outputs are masked by reset so an in-flight transaction is squashed in the reset cycle itself.
  assign in_access = (state_q == ACCESS) && !reset;
  assign in_resp   = (state_q == RESP) && !reset;

  assign mem_addr  = reset ? 32'd0 : addr_q;
  assign mem_wdata = reset ? 32'd0 : wdata_q;
  assign mem_rstrb = in_access && (wstrb_q == 4'd0);
  assign mem_wmask = in_access ? wstrb_q : 4'd0;
  assign grant     = reset ? 2'b00 : grant_q;

  assign m0_ready  = in_resp && grant_q[0];
  assign m1_ready  = in_resp && grant_q[1];
  assign m0_rdata  = m0_ready ? mem_rdata : 32'd0;
  assign m1_rdata  = m1_ready ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory model, transaction scoreboard and per-scenario tasks.
// Build with +define+MEM_ARBITER_ROUND_ROBIN_EN to exercise the round-robin configuration.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic        m0_ready, m1_ready, mem_rstrb;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_wmask;
  logic [1:0]  grant;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata), .grant(grant)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem_arr[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_rstrb) mem_rdata <= mem_arr[mem_addr[9:2]];
  end

  typedef struct {
    int          who;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb[$];
  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  int acc_cyc = -10;

  task automatic push(input int who, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    txn_t t;
    t.who = who; t.rd = (s == 4'd0); t.addr = a; t.wdata = w; t.wstrb = s;
    t.rdata = ref_mem[a[9:2]];
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[9:2]][b*8 +: 8] = w[b*8 +: 8];
    sb.push_back(t);
  endtask

  task automatic drive(input int who, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
    if (who == 0) begin m0_valid = 1; m0_addr = a; m0_wdata = w; m0_wstrb = s; end
    else          begin m1_valid = 1; m1_addr = a; m1_wdata = w; m1_wstrb = s; end
  endtask

  // Scoreboard monitor: checks each memory access and each ready pulse against the queue head.
  always @(negedge clk) begin
    if (!reset) begin
      txn_t e;
      cyc++;
      tests_run++;
      if ((m0_ready && m1_ready) || (!m0_ready && m0_rdata !== 32'd0) || (!m1_ready && m1_rdata !== 32'd0)) begin
        failed++;
        $display("FAIL idle_outputs: rdy=%b%b rdata0=%h rdata1=%h, required one ready max and idle rdata 0",
                 m0_ready, m1_ready, m0_rdata, m1_rdata);
      end
      if (mem_rstrb || mem_wmask != 4'd0) begin
        tests_run++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL unexpected_access: addr=%h rstrb=%b wmask=%b, required no access", mem_addr, mem_rstrb, mem_wmask);
        end else begin
          e = sb[0];
          if (grant !== (e.who == 0 ? 2'b01 : 2'b10) || mem_addr !== e.addr || mem_rstrb !== e.rd ||
              mem_wmask !== (e.rd ? 4'd0 : e.wstrb) || (!e.rd && mem_wdata !== e.wdata)) begin
            failed++;
            $display("FAIL access: grant=%b addr=%h wdata=%h rstrb=%b wmask=%b, required m%0d addr=%h wdata=%h wstrb=%b",
                     grant, mem_addr, mem_wdata, mem_rstrb, mem_wmask, e.who, e.addr, e.wdata, e.wstrb);
          end
        end
        acc_cyc = cyc;
      end
      if (m0_ready || m1_ready) begin
        tests_run++;
        if (sb.size() == 0) begin
          failed++;
          $display("FAIL unexpected_ready: rdy=%b%b, required none", m1_ready, m0_ready);
        end else begin
          e = sb.pop_front();
          if ((e.who == 0 ? m0_ready : m1_ready) !== 1'b1 || cyc !== acc_cyc + 1 ||
              (e.rd && (e.who == 0 ? m0_rdata : m1_rdata) !== e.rdata)) begin
            failed++;
            $display("FAIL response: rdy=%b%b rdata=%h lat=%0d, required m%0d rdata=%h lat=1",
                     m1_ready, m0_ready, m0_ready ? m0_rdata : m1_rdata, cyc - acc_cyc, e.who, e.rdata);
          end
        end
      end
    end
  end

  // Runs until n ready pulses; drops each requester's valid after its ready unless hold is set.
  task automatic run_until(input int n, input bit hold, input bit gap_chk);
    int seen = 0, prev = -1, spent = 0;
    bit d0, d1;
    while (seen < n && spent < 200) begin
      @(negedge clk); spent++;
      d0 = m0_ready; d1 = m1_ready;
      if (d0 || d1) begin
        seen++;
        if (gap_chk && prev >= 0) begin
          tests_run++;
          if (spent - prev !== 3) begin
            failed++;
            $display("FAIL ready_spacing: got %0d cycles, required 3", spent - prev);
          end
        end
        prev = spent;
      end
      @(posedge clk); #1;
      if (!hold) begin
        if (d0) m0_valid = 0;
        if (d1) m1_valid = 0;
      end
    end
    if (hold) begin m0_valid = 0; m1_valid = 0; end
    tests_run++;
    if (seen != n) begin
      failed++;
      $display("FAIL ready_timeout: got %0d readies, required %0d", seen, n);
    end
  endtask

  task automatic test_reset();
    reset = 1; m0_valid = 1; m0_wstrb = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({grant, m0_ready, m1_ready, mem_rstrb, mem_wmask, mem_addr, mem_wdata} !== '0) begin
      failed++;
      $display("FAIL reset_state: grant=%b rdy=%b%b rstrb=%b wmask=%b addr=%h wdata=%h, required all 0",
               grant, m1_ready, m0_ready, mem_rstrb, mem_wmask, mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
    m0_valid = 0; m0_wstrb = 0; reset = 0;
  endtask

  task automatic test_single_read();
    @(posedge clk); #1;
    push(0, 32'h10, 32'd0, 4'd0);
    drive(0, 32'h10, 32'd0, 4'd0);
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b00 || mem_rstrb !== 1'b0) begin
      failed++; $display("FAIL read_n: grant=%b rstrb=%b, required 00/0", grant, mem_rstrb);
    end
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b01 || mem_rstrb !== 1'b1 || mem_wmask !== 4'd0 || m0_ready !== 1'b0) begin
      failed++; $display("FAIL read_n1: grant=%b rstrb=%b wmask=%b rdy=%b, required 01/1/0000/0", grant, mem_rstrb, mem_wmask, m0_ready);
    end
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b01 || m0_ready !== 1'b1 || m0_rdata !== 32'hDEADBEEF || mem_rstrb !== 1'b0) begin
      failed++; $display("FAIL read_n2: grant=%b rdy=%b rdata=%h, required 01/1/deadbeef", grant, m0_ready, m0_rdata);
    end
    @(posedge clk); #1; m0_valid = 0;
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b00 || m0_ready !== 1'b0) begin
      failed++; $display("FAIL read_n3: grant=%b rdy=%b, required 00/0", grant, m0_ready);
    end
  endtask

  task automatic test_byte_write();
    int wcnt = 0, rdy_k = -1;
    bit m0_seen = 0;
    @(posedge clk); #1;
    push(1, 32'h20, 32'h000000AB, 4'b0001);
    drive(1, 32'h20, 32'h000000AB, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_wmask != 4'd0) begin
        wcnt++;
        tests_run++;
        if (mem_wmask !== 4'b0001) begin
          failed++; $display("FAIL write_mask: got %b, required 0001", mem_wmask);
        end
      end
      if (m1_ready) rdy_k = k;
      if (m0_ready) m0_seen = 1;
      if (k == 2) begin @(posedge clk); #1; m1_valid = 0; end
    end
    tests_run++;
    if (wcnt != 1 || rdy_k != 2 || m0_seen) begin
      failed++; $display("FAIL write_timing: wmask cycles=%0d ready at=%0d m0_ready=%b, required 1/2/0", wcnt, rdy_k, m0_seen);
    end
  endtask

  task automatic test_valid_drop();
    logic [31:0] exp;
    exp = ref_mem[32'h40 >> 2];
    @(posedge clk); #1;
    push(1, 32'h40, 32'd0, 4'd0);
    drive(1, 32'h40, 32'd0, 4'd0);
    @(negedge clk);
    @(posedge clk); #1;
    m1_valid = 0; m1_addr = 32'h80; m1_wstrb = 4'hF;
    @(negedge clk);
    tests_run++;
    if (mem_addr !== 32'h40 || mem_rstrb !== 1'b1 || mem_wmask !== 4'd0) begin
      failed++; $display("FAIL drop_access: addr=%h rstrb=%b wmask=%b, required 00000040/1/0000", mem_addr, mem_rstrb, mem_wmask);
    end
    @(negedge clk);
    tests_run++;
    if (m1_ready !== 1'b1 || m1_rdata !== exp) begin
      failed++; $display("FAIL drop_ready: rdy=%b rdata=%h, required 1/%h", m1_ready, m1_rdata, exp);
    end
    repeat (2) @(negedge clk);
    tests_run++;
    if (grant !== 2'b00) begin
      failed++; $display("FAIL drop_regrant: grant=%b, required 00", grant);
    end
    m1_wstrb = 4'd0;
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk); #1;
    drive(0, 32'h30, 32'h11111111, 4'hF);
    @(negedge clk);
    @(posedge clk); #1; reset = 1;
    @(negedge clk);
    tests_run++;
    if (mem_wmask !== 4'd0 || grant !== 2'b00 || m0_ready !== 1'b0 || mem_rstrb !== 1'b0) begin
      failed++; $display("FAIL abort: wmask=%b grant=%b rdy=%b rstrb=%b, required all 0", mem_wmask, grant, m0_ready, mem_rstrb);
    end
    @(posedge clk); #1;
    reset = 0; m0_wdata = 32'h00000022; m0_wstrb = 4'b0001;
    push(0, 32'h30, 32'h00000022, 4'b0001);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (grant !== 2'b01 || mem_wmask !== 4'b0001) begin
      failed++; $display("FAIL post_reset_access: grant=%b wmask=%b, required 01/0001", grant, mem_wmask);
    end
    @(negedge clk);
    tests_run++;
    if (m0_ready !== 1'b1) begin
      failed++; $display("FAIL post_reset_ready: got %b, required 1", m0_ready);
    end
    @(posedge clk); #1; m0_valid = 0;
    push(0, 32'h30, 32'd0, 4'd0);
    drive(0, 32'h30, 32'd0, 4'd0);
    run_until(1, 0, 0);
  endtask

  task automatic test_contention();
    reset = 1;
    @(posedge clk); #1;
    drive(0, 32'h50, 32'd0, 4'd0);
    drive(1, 32'h60, 32'd0, 4'd0);
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      push(i % 2, (i % 2 == 0) ? 32'h50 : 32'h60, 32'd0, 4'd0);
`else
      push(0, 32'h50, 32'd0, 4'd0);
`endif
    end
    run_until(6, 1, 1);
  endtask

  task automatic test_back_to_back();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    push(0, 32'h70, 32'h0000C300, 4'b0010);
    push(1, 32'h70, 32'd0, 4'd0);
    drive(0, 32'h70, 32'h0000C300, 4'b0010);
    drive(1, 32'h70, 32'd0, 4'd0);
    run_until(2, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = 32'hA5000000 | i;
      ref_mem[i] = 32'hA5000000 | i;
    end
    mem_arr[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    test_reset();
    test_single_read();
    test_byte_write();
    test_valid_drop();
    test_reset_mid_op();
    test_contention();
    test_back_to_back();
    repeat (3) @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      failed++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
